// File: rtl/fft_butterfly_combine.sv
// -----------------------------------------------------------------------------
// fft_butterfly_combine
//
// Radix-2 decimation-in-time butterfly back end. It sits directly after the
// complex twiddle multiplier. It takes the product W*B and the matching A
// operand, rounds the product back to data precision, and then forms
//   X = A + W*B
//   Y = A - W*B
// with optional per-stage divide-by-2 scaling. Results stream to the next
// stage with a valid strobe and a last-butterfly marker.
//
// Pipeline (a sample with i_valid in cycle t appears on o_valid in cycle
// t+MULT_LAT+2):
//   stage 0 : MULT_LAT-deep delay line for A and valid. Its tail lines up
//             with the multiplier product.
//   stage 1 : registered product rounding, W_B = (prod + 8192) >>> 14.
//   stage 2 : registered butterfly, optional scaling, reduction to 16 bits.
//
// Handshake: streaming with no backpressure. A sample is transferred on every
// cycle where i_valid is high, and o_valid is high for exactly one cycle per
// accepted sample. Data outputs hold their last value when o_valid is low.
//
// Parameters:
//   MULT_LAT : multiplier latency in cycles (>= 1)
//   SCALE    : 1 = halve the outputs with rounding, 0 = no scaling
//   LOG2N    : log2 of the FFT size (>= 2); there are 2^(LOG2N-1)
//              butterflies per stage
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   i_valid               sample strobe, in the multiplier input cycle
//   i_data_ar/ac          A operand, signed 16-bit
//   i_prod_r/c            twiddle product, signed 32-bit, MULT_LAT cycles later
//   o_valid, o_last       output strobe; marker for the final butterfly of a stage
//   o_data_xr/xc/yr/yc    X and Y outputs, signed 16-bit
//   o_ovf                 sticky saturation flag
//
// Optional feature macro: FFT_BFLY_SAT_EN
//   defined   : outputs saturate to 16 bits, and o_ovf latches any saturation
//               on an o_valid cycle until rst.
//   undefined : outputs wrap to their low 16 bits, and o_ovf is tied to 0.
// -----------------------------------------------------------------------------
module fft_butterfly_combine #(
    parameter int MULT_LAT = 1,
    parameter int SCALE    = 1,
    parameter int LOG2N    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic signed [15:0] i_data_ar,
    input  logic signed [15:0] i_data_ac,
    input  logic signed [31:0] i_prod_r,
    input  logic signed [31:0] i_prod_c,
    output logic               o_valid,
    output logic               o_last,
    output logic signed [15:0] o_data_xr,
    output logic signed [15:0] o_data_xc,
    output logic signed [15:0] o_data_yr,
    output logic signed [15:0] o_data_yc,
    output logic               o_ovf
);

    localparam int CW = LOG2N - 1;

    // ------------------------------------------------------------------
    // Stage 0: A / valid alignment delay line
    // ------------------------------------------------------------------
    logic               dl_v_q  [MULT_LAT];
    logic signed [15:0] dl_ar_q [MULT_LAT];
    logic signed [15:0] dl_ac_q [MULT_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                dl_v_q[i]  <= 1'b0;
                dl_ar_q[i] <= '0;
                dl_ac_q[i] <= '0;
            end
        end else begin
            dl_v_q[0]  <= i_valid;
            dl_ar_q[0] <= i_data_ar;
            dl_ac_q[0] <= i_data_ac;
            for (int i = 1; i < MULT_LAT; i++) begin
                dl_v_q[i]  <= dl_v_q[i-1];
                dl_ar_q[i] <= dl_ar_q[i-1];
                dl_ac_q[i] <= dl_ac_q[i-1];
            end
        end
    end

    logic               al_v;
    logic signed [15:0] al_ar;
    logic signed [15:0] al_ac;

    assign al_v  = dl_v_q[MULT_LAT-1];
    assign al_ar = dl_ar_q[MULT_LAT-1];
    assign al_ac = dl_ac_q[MULT_LAT-1];

    // ------------------------------------------------------------------
    // Stage 1: product rounding (round half up, arithmetic shift).
    // The sum is widened by one bit so that +8192 cannot wrap at the top of
    // the 32-bit range. A Q2.14 twiddle keeps the result within 17 bits.
    // ------------------------------------------------------------------
    logic signed [32:0] rnd_r;
    logic signed [32:0] rnd_c;
    logic signed [16:0] wb_r_d;
    logic signed [16:0] wb_c_d;

    always_comb begin
        rnd_r  = {i_prod_r[31], i_prod_r} + 33'sd8192;
        rnd_c  = {i_prod_c[31], i_prod_c} + 33'sd8192;
        wb_r_d = 17'(rnd_r >>> 14);
        wb_c_d = 17'(rnd_c >>> 14);
    end

    logic               s1_v_q;
    logic signed [15:0] s1_ar_q;
    logic signed [15:0] s1_ac_q;
    logic signed [16:0] s1_wbr_q;
    logic signed [16:0] s1_wbc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_ar_q  <= '0;
            s1_ac_q  <= '0;
            s1_wbr_q <= '0;
            s1_wbc_q <= '0;
        end else begin
            s1_v_q <= al_v;
            if (al_v) begin
                s1_ar_q  <= al_ar;
                s1_ac_q  <= al_ac;
                s1_wbr_q <= wb_r_d;
                s1_wbc_q <= wb_c_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: butterfly, optional scaling, 16-bit reduction
    // ------------------------------------------------------------------
    function automatic logic signed [17:0] scale18(input logic signed [17:0] v);
        logic signed [18:0] t;
        if (SCALE != 0) begin
            // Round half up: (v + 1) >>> 1. The extra bit absorbs the +1.
            t = {v[17], v} + 19'sd1;
            return 18'(t >>> 1);
        end else begin
            return v;
        end
    endfunction

`ifdef FFT_BFLY_SAT_EN
    function automatic logic signed [15:0] reduce16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7fff;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    function automatic logic is_sat(input logic signed [17:0] v);
        return (v > 18'sd32767) || (v < -18'sd32768);
    endfunction
`else
    function automatic logic signed [15:0] reduce16(input logic signed [17:0] v);
        return 16'(v);
    endfunction
`endif

    logic signed [17:0] pre_xr;
    logic signed [17:0] pre_xc;
    logic signed [17:0] pre_yr;
    logic signed [17:0] pre_yc;

    always_comb begin
        pre_xr = scale18({{2{s1_ar_q[15]}}, s1_ar_q} + {s1_wbr_q[16], s1_wbr_q});
        pre_xc = scale18({{2{s1_ac_q[15]}}, s1_ac_q} + {s1_wbc_q[16], s1_wbc_q});
        pre_yr = scale18({{2{s1_ar_q[15]}}, s1_ar_q} - {s1_wbr_q[16], s1_wbr_q});
        pre_yc = scale18({{2{s1_ac_q[15]}}, s1_ac_q} - {s1_wbc_q[16], s1_wbc_q});
    end

    logic               o_valid_q;
    logic               o_last_q;
    logic signed [15:0] xr_q;
    logic signed [15:0] xc_q;
    logic signed [15:0] yr_q;
    logic signed [15:0] yc_q;
    logic [CW-1:0]      cnt_q;

    // The butterfly counter advances in the same cycle that o_valid is
    // loaded. o_last is therefore registered against the pre-increment count.
    // The counter is exactly CW bits wide, so it wraps on its own after the
    // last butterfly.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            xr_q      <= '0;
            xc_q      <= '0;
            yr_q      <= '0;
            yc_q      <= '0;
            cnt_q     <= '0;
        end else begin
            o_valid_q <= s1_v_q;
            o_last_q  <= s1_v_q && (cnt_q == {CW{1'b1}});
            if (s1_v_q) begin
                xr_q  <= reduce16(pre_xr);
                xc_q  <= reduce16(pre_xc);
                yr_q  <= reduce16(pre_yr);
                yc_q  <= reduce16(pre_yc);
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef FFT_BFLY_SAT_EN
    logic ovf_q;
    logic any_sat;

    assign any_sat = is_sat(pre_xr) | is_sat(pre_xc) | is_sat(pre_yr) | is_sat(pre_yc);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s1_v_q && any_sat) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_valid   = o_valid_q;
    assign o_last    = o_last_q;
    assign o_data_xr = xr_q;
    assign o_data_xc = xc_q;
    assign o_data_yr = yr_q;
    assign o_data_yc = yc_q;

endmodule
